// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: shared opcode encodings and FSM state type for alu_acc_seq.
package alu_acc_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_EQ   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_ADC  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_acc_seq_if.sv
// alu_acc_seq_if: command/result bundle for alu_acc_seq.
//   master: drives start, op_sel, use_acc, a, b; observes results.
//   slave : the datapath; drives acc_out, acc_hi, carry_out, z, busy, done.
interface alu_acc_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op_sel;
  logic             use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] acc_hi;
  logic             carry_out;
  logic             z;
  logic             busy;
  logic             done;

  modport master (
    output start, op_sel, use_acc, a, b,
    input  acc_out, acc_hi, carry_out, z, busy, done
  );

  modport slave (
    input  start, op_sel, use_acc, a, b,
    output acc_out, acc_hi, carry_out, z, busy, done
  );
endinterface

// File: rtl/alu_acc_seq_mul.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per step.
//   clk, clb   : clock, async active-high clear
//   load       : capture a_in (multiplicand) and b_in (multiplier), clear partial
//   step       : one add-and-shift iteration
//   product    : value the product register takes after the current step;
//                after WIDTH steps it equals a_in*b_in
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clb,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product
);
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     upper_sum;

  // Low half starts as the multiplier and is shifted out LSB-first while the
  // upper half accumulates; product is exposed pre-register so the owner can
  // commit on the final step edge.
  always_comb begin
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : '0);
    product   = {upper_sum, prod_q[WIDTH-1:1]};
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    if (load) begin
      mcand_d = a_in;
      prod_d  = {{WIDTH{1'b0}}, b_in};
    end else if (step) begin
      prod_d  = product;
    end
  end

  always_ff @(posedge clk or posedge clb) begin
    if (clb) begin
      prod_q  <= '0;
      mcand_q <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
    end
  end
endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: parametrised ALU + accumulator with iterative multiply.
//   clk      : rising-edge clock
//   clb      : asynchronous active-high clear
//   bus      : alu_acc_seq_if.slave -- start/op_sel/use_acc/a/b in,
//              acc_out/acc_hi/carry_out/z/busy/done out (all registered)
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         clb,
  alu_acc_seq_if.slave bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic               c_q, c_d;
  logic               z_q, z_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               mul_load, mul_step;
  logic [2*WIDTH-1:0] mul_prod;

  assign op_a = bus.use_acc ? acc_q : bus.a;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .clb     (clb),
    .load    (mul_load),
    .step    (mul_step),
    .a_in    (op_a),
    .b_in    (bus.b),
    .product (mul_prod)
  );

  // Single-cycle result; MUL/NOP fall through to "hold".
  always_comb begin
    alu_res = acc_q;
    alu_c   = c_q;
    case (bus.op_sel)
      OP_PASS: begin alu_res = op_a;               alu_c = 1'b0;         end
      OP_ADD:  {alu_c, alu_res} = {1'b0, op_a} + {1'b0, bus.b};
      OP_SUB:  begin alu_res = op_a - bus.b;      alu_c = (op_a < bus.b); end
      OP_NOR:  begin alu_res = ~(op_a | bus.b);   alu_c = 1'b0;         end
      OP_AND:  begin alu_res = op_a & bus.b;      alu_c = 1'b0;         end
      OP_OR:   begin alu_res = op_a | bus.b;      alu_c = 1'b0;         end
      OP_EQ:   begin alu_res = WIDTH'(op_a == bus.b); alu_c = 1'b0;     end
      OP_XOR:  begin alu_res = op_a ^ bus.b;      alu_c = 1'b0;         end
      OP_LT:   begin alu_res = WIDTH'(op_a < bus.b);  alu_c = 1'b0;     end
      OP_ADC:  {alu_c, alu_res} = {1'b0, op_a} + {1'b0, bus.b}
                                + {{WIDTH{1'b0}}, c_q};
      OP_SHL:  begin alu_res = {op_a[WIDTH-2:0], 1'b0};  alu_c = op_a[WIDTH-1]; end
      OP_SHR:  begin alu_res = {1'b0, op_a[WIDTH-1:1]};  alu_c = op_a[0];       end
      OP_ROL:  begin alu_res = {op_a[WIDTH-2:0], op_a[WIDTH-1]}; alu_c = op_a[WIDTH-1]; end
      OP_ROR:  begin alu_res = {op_a[0], op_a[WIDTH-1:1]};       alu_c = op_a[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    acc_hi_d = acc_hi_q;
    c_d      = c_q;
    z_d      = z_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op_sel == OP_MUL) begin
            mul_load = 1'b1;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = ST_MUL_RUN;
          end else begin
            done_d = 1'b1;
            if (bus.op_sel != OP_NOP) begin
              acc_d = alu_res;
              c_d   = alu_c;
              z_d   = (alu_res == '0);
            end
          end
        end
      end
      ST_MUL_RUN: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          acc_d    = mul_prod[WIDTH-1:0];
          acc_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          c_d      = |mul_prod[2*WIDTH-1:WIDTH];
          z_d      = (mul_prod[WIDTH-1:0] == '0);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clb) begin
    if (clb) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      acc_hi_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      acc_hi_q <= acc_hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.acc_hi    = acc_hi_q;
  assign bus.carry_out = c_q;
  assign bus.z         = z_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: self-checking bench for alu_acc_seq at WIDTH=8 and WIDTH=16.
module tb_alu_acc_seq;
  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic clb = 1'b1;
  always #5 clk = ~clk;

  alu_acc_seq_if #(.WIDTH(W))   bus();
  alu_acc_seq_if #(.WIDTH(W16)) bus16();

  alu_acc_seq #(.WIDTH(W))   dut   (.clk(clk), .clb(clb), .bus(bus));
  alu_acc_seq #(.WIDTH(W16)) dut16 (.clk(clk), .clb(clb), .bus(bus16));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural state.
  int unsigned m_acc = 0, m_hi = 0;
  int unsigned m_c = 0;

  function automatic void model(input logic [3:0] op, input bit ua,
                                input int unsigned av, input int unsigned bv);
    int unsigned x = ua ? m_acc : av;
    longint unsigned r;
    case (op)
      4'h0: begin m_acc = x; m_c = 0; end
      4'h1: begin r = x + bv; m_acc = int'(r % 256); m_c = (r >= 256) ? 1 : 0; end
      4'h2: begin m_acc = (x + 256 - bv) % 256; m_c = (x < bv) ? 1 : 0; end
      4'h3: begin m_acc = 255 - (x | bv); m_c = 0; end
      4'h4: begin m_acc = x & bv; m_c = 0; end
      4'h5: begin m_acc = x | bv; m_c = 0; end
      4'h6: begin m_acc = (x == bv) ? 1 : 0; m_c = 0; end
      4'h7: begin m_acc = x ^ bv; m_c = 0; end
      4'h8: begin m_acc = (x < bv) ? 1 : 0; m_c = 0; end
      4'h9: begin r = longint'(x) * bv; m_acc = int'(r % 256); m_hi = int'(r / 256);
                  m_c = (m_hi != 0) ? 1 : 0; end
      4'hA: begin r = x + bv + m_c; m_acc = int'(r % 256); m_c = (r >= 256) ? 1 : 0; end
      4'hB: begin m_acc = (x * 2) % 256; m_c = x / 128; end
      4'hC: begin m_acc = x / 2; m_c = x % 2; end
      4'hD: begin m_acc = (x * 2) % 256 + x / 128; m_c = x / 128; end
      4'hE: begin m_acc = x / 2 + (x % 2) * 128; m_c = x % 2; end
      default: ;
    endcase
  endfunction

  // Issue one command on the 8-bit instance and check the handshake; with
  // chk_model set, also compare all results against the model.
  task automatic issue(input logic [3:0] op, input bit ua, input logic [7:0] av,
                       input logic [7:0] bv, input bit chk_model);
    int unsigned pre_acc = m_acc;
    int unsigned pre_c   = m_c;
    int lat = 0;
    bus.op_sel = op; bus.use_acc = ua; bus.a = av; bus.b = bv; bus.start = 1'b1;
    model(op, ua, av, bv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op == 4'h9) begin
      chk("mul_busy_start", bus.busy, 1);
      chk("mul_done_start", bus.done, 0);
      chk("mul_acc_hold", bus.acc_out, pre_acc);
      chk("mul_c_hold", bus.carry_out, pre_c);
      // Disturb every input while running; none of it may take effect.
      bus.start = 1'b1; bus.op_sel = 4'h1; bus.use_acc = ~ua;
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      for (int i = 1; i <= W + 4; i++) begin
        @(posedge clk); #1;
        if (bus.done) begin lat = i; break; end
        chk("mul_busy_run", bus.busy, 1);
      end
      bus.start = 1'b0;
      chk("mul_latency", lat, W);
      chk("mul_busy_end", bus.busy, 0);
    end else begin
      chk("op_done", bus.done, 1);
    end
    if (chk_model) begin
      chk($sformatf("op%0h_acc", op), bus.acc_out, m_acc);
      chk($sformatf("op%0h_hi", op), bus.acc_hi, m_hi);
      chk($sformatf("op%0h_c", op), bus.carry_out, m_c);
      chk($sformatf("op%0h_z", op), bus.z, (m_acc == 0) ? 1 : 0);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    bit         ua;
    logic [7:0] a, b;
    logic [7:0] acc;
    bit         c, z;
  } vec_t;

  vec_t tv[20];

  initial begin
    tv[0]  = '{4'h1, 1'b0, 8'd15,  8'd10,  8'd25,  1'b0, 1'b0}; // ADD
    tv[1]  = '{4'h1, 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0}; // ADD ovf
    tv[2]  = '{4'hA, 1'b0, 8'd0,   8'd0,   8'd1,   1'b0, 1'b0}; // ADC
    tv[3]  = '{4'h2, 1'b0, 8'd20,  8'd25,  8'hFB,  1'b1, 1'b0}; // SUB borrow
    tv[4]  = '{4'h2, 1'b0, 8'd30,  8'd30,  8'h00,  1'b0, 1'b1}; // SUB zero
    tv[5]  = '{4'h0, 1'b0, 8'd5,   8'd0,   8'd5,   1'b0, 1'b0}; // PASS
    tv[6]  = '{4'h1, 1'b1, 8'hEE,  8'd3,   8'd8,   1'b0, 1'b0}; // ADD acc
    tv[7]  = '{4'hB, 1'b1, 8'hEE,  8'd0,   8'd16,  1'b0, 1'b0}; // SHL acc
    tv[8]  = '{4'hB, 1'b0, 8'h81,  8'd0,   8'h02,  1'b1, 1'b0}; // SHL
    tv[9]  = '{4'hE, 1'b0, 8'h01,  8'd0,   8'h80,  1'b1, 1'b0}; // ROR
    tv[10] = '{4'h6, 1'b0, 8'd30,  8'd30,  8'd1,   1'b0, 1'b0}; // EQ
    tv[11] = '{4'h8, 1'b0, 8'd10,  8'd20,  8'd1,   1'b0, 1'b0}; // LT
    tv[12] = '{4'h8, 1'b0, 8'd20,  8'd10,  8'd0,   1'b0, 1'b1}; // LT false
    tv[13] = '{4'h3, 1'b0, 8'hAA,  8'h55,  8'h00,  1'b0, 1'b1}; // NOR
    tv[14] = '{4'h7, 1'b0, 8'hF0,  8'hFF,  8'h0F,  1'b0, 1'b0}; // XOR
    tv[15] = '{4'h4, 1'b0, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0}; // AND
    tv[16] = '{4'h5, 1'b0, 8'h0F,  8'h30,  8'h3F,  1'b0, 1'b0}; // OR
    tv[17] = '{4'hD, 1'b0, 8'h80,  8'd0,   8'h01,  1'b1, 1'b0}; // ROL
    tv[18] = '{4'hC, 1'b0, 8'h01,  8'd0,   8'h00,  1'b1, 1'b1}; // SHR
    tv[19] = '{4'hF, 1'b0, 8'hFF,  8'hFF,  8'h00,  1'b1, 1'b1}; // NOP holds
  end

  initial begin : main
    int seen;
    int lat;
    bus.start = 1'b0; bus.op_sel = 4'h0; bus.use_acc = 1'b0; bus.a = '0; bus.b = '0;
    bus16.start = 1'b0; bus16.op_sel = 4'h0; bus16.use_acc = 1'b0; bus16.a = '0; bus16.b = '0;

    repeat (2) @(posedge clk);
    #1 clb = 1'b0;
    chk("rst_acc", bus.acc_out, 0);
    chk("rst_hi", bus.acc_hi, 0);
    chk("rst_c", bus.carry_out, 0);
    chk("rst_z", bus.z, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // Clear in the middle of a MUL: nothing may be committed afterwards.
    bus.op_sel = 4'h9; bus.a = 8'd200; bus.b = 8'd200; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("abort_busy_before", bus.busy, 1);
    repeat (3) @(posedge clk);
    #1 clb = 1'b1;
    #1 chk("abort_busy_async", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 clb = 1'b0;
    chk("abort_acc", bus.acc_out, 0);
    chk("abort_hi", bus.acc_hi, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_z", bus.z, 1);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort_no_commit", seen, 0);
    chk("abort_acc_after", bus.acc_out, 0);
    chk("abort_hi_after", bus.acc_hi, 0);
    m_acc = 0; m_hi = 0; m_c = 0;

    // Directed table, back-to-back (done must stay high throughout).
    for (int i = 0; i < 20; i++) begin
      issue(tv[i].op, tv[i].ua, tv[i].a, tv[i].b, 1'b0);
      chk($sformatf("tbl%0d_acc", i), bus.acc_out, tv[i].acc);
      chk($sformatf("tbl%0d_c", i), bus.carry_out, tv[i].c);
      chk($sformatf("tbl%0d_z", i), bus.z, tv[i].z);
      chk($sformatf("tbl%0d_hi", i), bus.acc_hi, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse_drop", bus.done, 0);

    // Multiply sequences.
    issue(4'h9, 1'b0, 8'd13, 8'd17, 1'b1);
    chk("mul13x17_acc", bus.acc_out, 8'hDD);
    chk("mul13x17_hi", bus.acc_hi, 8'h00);
    chk("mul13x17_c", bus.carry_out, 0);
    @(posedge clk); #1;
    chk("mul_done_pulse", bus.done, 0);
    chk("mul_acc_stable", bus.acc_out, 8'hDD);
    issue(4'h9, 1'b0, 8'd200, 8'd200, 1'b1);
    chk("mul200_acc", bus.acc_out, 8'h40);
    chk("mul200_hi", bus.acc_hi, 8'h9C);
    chk("mul200_c", bus.carry_out, 1);
    chk("mul200_z", bus.z, 0);
    issue(4'h1, 1'b1, 8'd0, 8'd1, 1'b1);   // acc_hi must not move on ADD
    chk("hi_after_add", bus.acc_hi, 8'h9C);

    // Randomised ops against the model.
    for (int i = 0; i < 250; i++) begin
      issue(4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rand_idle_done", bus.done, 0);
      end
    end

    // WIDTH=16 instance.
    bus16.op_sel = 4'h1; bus16.a = 16'hFFFF; bus16.b = 16'h0002; bus16.start = 1'b1;
    @(posedge clk); #1 bus16.start = 1'b0;
    chk("w16_add_acc", bus16.acc_out, 16'h0001);
    chk("w16_add_c", bus16.carry_out, 1);
    chk("w16_add_done", bus16.done, 1);
    bus16.op_sel = 4'h9; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.start = 1'b1;
    @(posedge clk); #1 bus16.start = 1'b0;
    chk("w16_mul_busy", bus16.busy, 1);
    lat = 0;
    for (int i = 1; i <= W16 + 4; i++) begin
      @(posedge clk); #1;
      if (bus16.done) begin lat = i; break; end
    end
    chk("w16_mul_latency", lat, W16);
    chk("w16_mul_acc", bus16.acc_out, 16'h0001);
    chk("w16_mul_hi", bus16.acc_hi, 16'hFFFE);
    chk("w16_mul_c", bus16.carry_out, 1);
    chk("w16_mul_z", bus16.z, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Parametrised ALU-plus-accumulator datapath, the successor to the 8-bit single-cycle ALU/accumulator system. Adds a configurable width, an accumulator-as-operand mode, rotate and add-with-carry ops, and an iterative multi-cycle multiply with a start/busy/done handshake. It sits between the instruction/control logic and the register file, and is the system's arithmetic engine.

Parameters:
WIDTH, 8, datapath width in bits; must be at least 4.
CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
clk  in  1  system clock, rising edge
clb  in  1  asynchronous, active-high reset (clear)
start  in  1  issue operation; sampled only when busy=0
op_sel  in  4  opcode
use_acc  in  1  1: operand A = acc_out; 0: operand A = a
a  in  WIDTH  operand A
b  in  WIDTH  operand B
acc_out  out  WIDTH  accumulator (low result)
acc_hi  out  WIDTH  upper half of last MUL product
carry_out  out  1  carry/borrow/shift-out flag
z  out  1  acc_out == 0
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: result committed

Behaviour:
- Reset (clb=1, async): acc_out=0, acc_hi=0, carry_out=0, z=1, busy=0, done=0, FSM=IDLE, counter=0. Asserting clb mid-MUL aborts the MUL with no partial commit.
- All outputs are registered. z is recomputed whenever acc_out is written.
- Opcodes (opA = use_acc ? acc_out : a):
  - 0000 PASS: acc=opA, C=0.
  - 0001 ADD: {C,acc}=opA+b.
  - 0010 SUB: acc=opA-b mod 2^WIDTH, C=(opA<b) (borrow).
  - 0011 NOR, 0100 AND, 0101 OR, 0111 XOR: bitwise; C=0.
  - 0110 EQ: acc=(opA==b), zero-extended; C=0.
  - 1000 LT: acc=(opA<b), unsigned, zero-extended; C=0.
  - 1001 MUL: multi-cycle; see below.
  - 1010 ADC: {C,acc}=opA+b+carry_out (old flag).
  - 1011 SHL: acc=opA<<1, C=opA[MSB].
  - 1100 SHR: logical, acc=opA>>1, C=opA[0].
  - 1101 ROL and 1110 ROR: rotate by 1; C=the bit rotated across.
  - 1111 NOP: acc and flags unchanged; done still pulses.
- Single-cycle ops: start=1 in IDLE at edge k commits acc, C and z at edge k, with done=1 for the following cycle. Back-to-back starts every cycle are legal; done stays high continuously in that case.
- acc_hi changes only on MUL.
- MUL FSM states:
  - IDLE: start with MUL latches opA and b, clears the partial product and counter, goes to MUL_RUN, sets busy=1.
  - MUL_RUN: one shift-add iteration per cycle, WIDTH iterations. On the final iteration edge it sets {acc_hi,acc}=opA*b (unsigned, 2*WIDTH bits), C=|acc_hi, z from acc only, busy=0, done=1, and returns to IDLE.
  - Latency: done is seen WIDTH cycles after the start edge.
- start while busy=1 is ignored: no queueing, and operands are not resampled. Changes to a, b, op_sel or use_acc during MUL_RUN have no effect.
- Flags are not updated while busy; they hold their pre-MUL values until the commit.

Decomposition:
- Package alu_acc_pkg: opcode localparams (OP_PASS…OP_NOP) and FSM state encoding (ST_IDLE, ST_MUL_RUN).
- One sub-module, seq_multiplier: shift-add core with WIDTH parameter, load/step inputs and a product output.
- Top level: operand mux, single-cycle ALU case, flag logic, FSM and handshake.

Test Plan:
- Reset: assert clb for 2 cycles mid-MUL (200×200) → acc_out=0, acc_hi=0, busy=0, done=0, z=1, no later commit.
- ADD 15+10 → acc=25, C=0, z=0, done for 1 cycle. ADD 200+100 → acc=44, C=1. Then ADC 0+0 → acc=1.
- SUB 20-25 → acc=0xFB, C=1. SUB 30-30 → acc=0, C=0, z=1.
- MUL 13×17 → busy for 8 cycles, then acc=0xDD, acc_hi=0, C=0. MUL 200×200 → acc=0x40, acc_hi=0x9C, C=1. start with ADD during busy is ignored.
- Chaining: PASS a=5; ADD use_acc b=3 → 8; SHL use_acc → 16, C=0. SHL a=0x81 → 0x02, C=1. ROR a=0x01 → 0x80, C=1.
- Compare/logic: EQ 30,30 → acc=1, z=0. LT 10,20 → 1. LT 20,10 → 0, z=1. NOR 0xAA,0x55 → 0x00, z=1. Repeat ADD/MUL at WIDTH=16: 0xFFFF×0xFFFF → acc=0x0001, acc_hi=0xFFFE.
